// File: rtl/sys_clk_pkg.sv
// Shared definitions for the system clock-enable generator.
//   state_e        : sequencer states (wait for lock, hold core in reset, run)
//   *_DEF          : default filter/hold lengths and divider ratios for the
//                    53.693175 MHz PLL clock
package sys_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int unsigned LOCK_FILT_DEF = 16;
  localparam int unsigned RST_HOLD_DEF  = 1024;
  localparam int unsigned DIV_MAIN_DEF  = 7;        // 68000 main: 7.67 MHz
  localparam int unsigned DIV_Z80_DEF   = 15;       // Z80: 3.58 MHz
  localparam int unsigned SUB_NUM_DEF   = 500000;   // 12.5 / 53.693175 MHz
  localparam int unsigned SUB_DEN_DEF   = 2147727;

endpackage

// File: rtl/ce_frac_div.sv
// Fractional clock-enable generator: issues NUM pulses every DEN enabled
// cycles using a phase accumulator (NUM < DEN, and NUM/DEN < 1/2 keeps the
// pulses from ever landing on consecutive cycles).
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   clr    in   synchronous clear of the accumulator (restart phase at 0)
//   en     in   advance the accumulator this cycle
//   ce     out  registered 1-cycle enable pulse
module ce_frac_div
  import sys_clk_pkg::*;
#(
  parameter int unsigned NUM = SUB_NUM_DEF,
  parameter int unsigned DEN = SUB_DEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic ce
);

  // One spare bit: acc < DEN and NUM < DEN, so acc + NUM < 2*DEN always fits.
  localparam int unsigned AW = $clog2(DEN) + 1;

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;
  logic          wrap;

  assign sum  = acc + AW'(NUM);
  assign wrap = (sum >= AW'(DEN));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
      ce  <= 1'b0;
    end else if (en) begin
      acc <= wrap ? (sum - AW'(DEN)) : sum;
      ce  <= wrap;
    end else begin
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/sys_clk_ce_gen.sv
// System clock-enable generator. Filters the PLL lock flag, holds the core in
// reset until lock has been stable long enough, then produces the per-CPU
// clock enables on clk_sys.
// Ports:
//   clk_sys     in   PLL system clock, 53.693175 MHz
//   reset       in   synchronous active-high user/host reset
//   pll_locked  in   PLL lock flag, asynchronous to clk_sys
//   pause       in   1 freezes all enables (core_reset unaffected)
//   core_reset  out  synchronous active-high reset to the core
//   ce_main     out  1-cycle pulse, 1 in DIV_MAIN cycles
//   ce_z80      out  1-cycle pulse, 1 in DIV_Z80 cycles
//   ce_sub      out  1-cycle pulse, SUB_NUM per SUB_DEN cycles
//   running     out  1 while the sequencer is in RUN
module sys_clk_ce_gen
  import sys_clk_pkg::*;
#(
  parameter int unsigned LOCK_FILT = LOCK_FILT_DEF,
  parameter int unsigned RST_HOLD  = RST_HOLD_DEF,
  parameter int unsigned DIV_MAIN  = DIV_MAIN_DEF,
  parameter int unsigned DIV_Z80   = DIV_Z80_DEF,
  parameter int unsigned SUB_NUM   = SUB_NUM_DEF,
  parameter int unsigned SUB_DEN   = SUB_DEN_DEF
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
  input  logic pause,
  output logic core_reset,
  output logic ce_main,
  output logic ce_z80,
  output logic ce_sub,
  output logic running
);

  localparam int unsigned CNT_MAX = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned MAIN_W  = $clog2(DIV_MAIN + 1);
  localparam int unsigned Z80_W   = $clog2(DIV_Z80 + 1);

  // ---------------------------------------------------------------------------
  // Lock synchronizer
  // ---------------------------------------------------------------------------
  logic lk_m;
  logic lk_s;

  // NOTE: the synchronizer flops carry no reset; they only ever hold a sampled
  // copy of pll_locked, and a reset term would just add logic in front of the
  // first (metastable) stage.
  always_ff @(posedge clk_sys) begin
    lk_m <= pll_locked;
    lk_s <= lk_m;
  end

  // ---------------------------------------------------------------------------
  // Lock filter / reset-hold sequencer
  // ---------------------------------------------------------------------------
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every signal written here is given a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (!lk_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(LOCK_FILT - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    if (reset) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end
  end

  // core_reset/running are registered from the next state so they change on
  // the same edge as the state itself (core_reset rises on the edge that
  // leaves RUN, not one cycle later).
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      core_reset <= 1'b1;
      running    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      core_reset <= (state_d != RUN);
      running    <= (state_d == RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Clock enables
  // ---------------------------------------------------------------------------
  // Dividers advance only on cycles that start and end in RUN, so the edge
  // entering RUN does not count and the first pulse lands DIV cycles later.
  logic ce_en;
  logic run_clr;

  assign ce_en   = (state_q == RUN) && (state_d == RUN) && !pause;
  assign run_clr = (state_d != RUN);

  logic [MAIN_W-1:0] main_cnt;
  logic [Z80_W-1:0]  z80_cnt;
  logic              main_last;
  logic              z80_last;

  assign main_last = (main_cnt == MAIN_W'(DIV_MAIN - 1));
  assign z80_last  = (z80_cnt  == Z80_W'(DIV_Z80 - 1));

  always_ff @(posedge clk_sys) begin
    if (reset || run_clr) begin
      main_cnt <= '0;
      z80_cnt  <= '0;
      ce_main  <= 1'b0;
      ce_z80   <= 1'b0;
    end else if (ce_en) begin
      main_cnt <= main_last ? '0 : main_cnt + MAIN_W'(1);
      z80_cnt  <= z80_last  ? '0 : z80_cnt  + Z80_W'(1);
      ce_main  <= main_last;
      ce_z80   <= z80_last;
    end else begin
      // Paused: counters hold their phase, pulses are suppressed.
      ce_main  <= 1'b0;
      ce_z80   <= 1'b0;
    end
  end

  ce_frac_div #(
    .NUM (SUB_NUM),
    .DEN (SUB_DEN)
  ) u_sub_div (
    .clk   (clk_sys),
    .reset (reset),
    .clr   (run_clr),
    .en    (ce_en),
    .ce    (ce_sub)
  );

endmodule

// File: tb/tb_sys_clk_ce_gen.sv
// Testbench for sys_clk_ce_gen. A behavioural reference model predicts, per
// clock edge, when the core comes out of reset and when each enable pulses;
// predictions go into queues and a monitor on the falling edge checks every
// DUT event against them. Directed sequences exercise the lock filter, the
// reset hold, lock loss, reset mid-run and pause, with randomized pause
// patterns and glitch positions.
module tb_sys_clk_ce_gen;

  localparam int    LF  = 16;
  localparam int    RH  = 1024;
  localparam int    DM  = 7;
  localparam int    DZ  = 15;
  localparam longint NUM = 500000;
  localparam longint DEN = 2147727;

  logic clk_sys    = 1'b0;
  logic reset      = 1'b1;
  logic pll_locked = 1'b1;
  logic pause      = 1'b0;
  logic core_reset;
  logic ce_main;
  logic ce_z80;
  logic ce_sub;
  logic running;

  sys_clk_ce_gen dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pll_locked (pll_locked),
    .pause      (pause),
    .core_reset (core_reset),
    .ce_main    (ce_main),
    .ce_z80     (ce_z80),
    .ce_sub     (ce_sub),
    .running    (running)
  );

  always #5 clk_sys = ~clk_sys;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the core runs once lk_s has been high for LF+RH
  // consecutive edges without a reset; enabled edge number k within a run
  // pulses main when k%DM==0, z80 when k%DZ==0, sub when floor(k*NUM/DEN)
  // steps up.
  // ---------------------------------------------------------------------------
  typedef struct {
    longint cyc;
    bit     run;
  } ev_t;

  longint q_ce[3][$];
  ev_t    q_state[$];

  longint edge_n = 0;
  bit     l1 = 1'b0, l2 = 1'b0;
  int     streak = 0;
  bit     run_m = 1'b0;
  longint k = 0;

  always @(posedge clk_sys) begin : ref_model
    bit  lks;
    bit  run_prev;
    bit  en;
    ev_t ev;
    edge_n++;
    lks = l2;
    l2  = l1;
    l1  = pll_locked;
    run_prev = run_m;
    if (reset || !lks) streak = 0;
    else if (streak < LF + RH) streak++;
    run_m = (streak >= LF + RH);
    en = run_prev && run_m && !pause;
    if (!run_m) begin
      k = 0;
    end else if (en) begin
      k++;
      if (k % DM == 0) q_ce[0].push_back(edge_n);
      if (k % DZ == 0) q_ce[1].push_back(edge_n);
      if ((k * NUM) / DEN != ((k - 1) * NUM) / DEN) q_ce[2].push_back(edge_n);
    end
    if (run_m != run_prev) begin
      ev.cyc = edge_n;
      ev.run = run_m;
      q_state.push_back(ev);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  longint mon_n = 0;
  logic   prev_rst = 1'b1;
  logic   prev_run = 1'b0;
  logic   prev_sub = 1'b0;
  string  ce_nm[3] = '{"ce_main", "ce_z80", "ce_sub"};

  always @(negedge clk_sys) begin : monitor
    logic [2:0] ce_v;
    ev_t        ev;
    mon_n++;
    ce_v = {ce_sub, ce_z80, ce_main};
    for (int i = 0; i < 3; i++) begin
      while (q_ce[i].size() > 0 && q_ce[i][0] < mon_n)
        check({ce_nm[i], " missed pulse"}, -1, q_ce[i].pop_front());
      if (ce_v[i]) begin
        if (q_ce[i].size() == 0) check({ce_nm[i], " unexpected pulse"}, mon_n, -1);
        else                     check({ce_nm[i], " pulse cycle"}, mon_n, q_ce[i].pop_front());
      end
    end
    if (ce_sub) check("ce_sub previous cycle", prev_sub, 0);
    while (q_state.size() > 0 && q_state[0].cyc < mon_n) begin
      ev = q_state.pop_front();
      check("core_reset missed transition", -1, ev.cyc);
    end
    if (core_reset !== prev_rst || running !== prev_run) begin
      if (q_state.size() == 0) begin
        check("core_reset unexpected transition", mon_n, -1);
      end else begin
        ev = q_state.pop_front();
        check("core_reset transition cycle", mon_n, ev.cyc);
        check("core_reset value", core_reset, !ev.run);
        check("running value", running, ev.run);
      end
    end
    prev_rst = core_reset;
    prev_run = running;
    prev_sub = ce_sub;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Release reset and raise lock (except one low cycle at glitch_at, if >= 0);
  // returns the number of edges until core_reset is seen low, or -1.
  task automatic release_and_measure(input int glitch_at, output int cycles);
    reset  = 1'b0;
    cycles = 0;
    for (int i = 0; i < 5000; i++) begin
      pll_locked = (i != glitch_at);
      @(negedge clk_sys);
      cycles++;
      if (!core_reset) return;
    end
    cycles = -1;
  endtask

  // Reset with lock low long enough to flush the synchronizer.
  task automatic park();
    reset      = 1'b1;
    pll_locked = 1'b0;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic count_pulses(input int n, output int c_main, output int c_z80, output int c_sub);
    c_main = 0; c_z80 = 0; c_sub = 0;
    repeat (n) begin
      @(negedge clk_sys);
      c_main += int'(ce_main);
      c_z80  += int'(ce_z80);
      c_sub  += int'(ce_sub);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : stim
    int cyc;
    int cm, cz, cs;
    int g;

    // Reset held with lock high.
    repeat (5) @(negedge clk_sys);
    check("reset core_reset", core_reset, 1);
    check("reset ce_main", ce_main, 0);
    check("reset ce_z80", ce_z80, 0);
    check("reset ce_sub", ce_sub, 0);
    check("reset running", running, 0);

    // Lock rises together with reset release: sync + filter + hold.
    park();
    release_and_measure(-1, cyc);
    check("release to run", cyc, 2 + LF + RH);
    check("running at release", running, 1);

    // First 105 running cycles: 15 main, 7 z80 pulses.
    count_pulses(DM * DZ, cm, cz, cs);
    check("ce_main count in 105", cm, DZ);
    check("ce_z80 count in 105", cz, DM);

    // Pause freezes every enable.
    count_pulses(13, cm, cz, cs);
    pause = 1'b1;
    count_pulses(20, cm, cz, cs);
    check("paused pulse total", cm + cz + cs, 0);
    pause = 1'b0;
    count_pulses(60, cm, cz, cs);

    // One-cycle glitch after 10 high cycles restarts the filter.
    park();
    release_and_measure(10, cyc);
    check("glitch at 10 release", cyc, 2 + 11 + LF + RH);

    // Randomized pause pattern while running.
    for (int i = 0; i < 4000; i++) begin
      pause = ($urandom_range(0, 3) == 0);
      @(negedge clk_sys);
    end
    pause = 1'b0;

    // Lock lost mid-run: core_reset after sync latency + 1.
    pll_locked = 1'b0;
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_sys);
      if (core_reset) begin
        cyc = i;
        break;
      end
    end
    check("lock loss to core_reset", cyc, 3);
    check("running after lock loss", running, 0);
    repeat (3) @(negedge clk_sys);
    release_and_measure(-1, cyc);
    check("relock to run", cyc, 2 + LF + RH);

    // Random glitch positions during the filter/hold window.
    for (int t = 0; t < 3; t++) begin
      park();
      g = int'($urandom_range(0, 1000));
      release_and_measure(g, cyc);
      check($sformatf("glitch at %0d release", g), cyc, 2 + g + 1 + LF + RH);
      for (int i = 0; i < 300; i++) begin
        pause = ($urandom_range(0, 4) == 0);
        @(negedge clk_sys);
      end
      pause = 1'b0;
    end

    // Reset mid-run with lock steady: synchronizer already full.
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("core_reset during reset", core_reset, 1);
    check("ce_main during reset", ce_main, 0);
    release_and_measure(-1, cyc);
    check("reset mid-run to run", cyc, LF + RH);
    count_pulses(200, cm, cz, cs);

    // Drain and confirm nothing predicted was left unobserved.
    repeat (5) @(negedge clk_sys);
    for (int i = 0; i < 3; i++)
      check({ce_nm[i], " pending at end"}, q_ce[i].size(), 0);
    check("state events pending at end", q_state.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
